// File: rtl/redmule_pkg.sv
// Shared RedMulE definitions for the MX datapath.
// Block size, exponent width and exponent-unpacker FSM states.
package redmule_pkg;

  localparam int unsigned MX_BLK_SIZE = 32;
  localparam int unsigned MX_EXP_W    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mx_exp_unpack_state_e;

endpackage

// File: rtl/redmule_mx_exp_unpacker.sv
// Splits 64-byte MX exponent beats into one shared exponent per handshake.
// Optional protocol checker: define REDMULE_MX_EXP_CHECK_EN.
module redmule_mx_exp_unpacker
  import redmule_pkg::*;
#(
  parameter int unsigned BEAT_W = 512,
  parameter int unsigned EXP_W  = MX_EXP_W,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  num_blocks_i,
  input  logic              exp_valid_i,
  output logic              exp_ready_o,
  input  logic [BEAT_W-1:0] exp_data_i,
  output logic              blk_exp_valid_o,
  input  logic              blk_exp_ready_i,
  output logic [EXP_W-1:0]  blk_exp_o,
  output logic [CNT_W-1:0]  blk_idx_o,
  output logic              last_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int unsigned EPB   = BEAT_W / EXP_W;
  localparam int unsigned IDX_W = $clog2(EPB);

  mx_exp_unpack_state_e state_q, state_d;

  logic [CNT_W-1:0]  nb_q;
  logic [CNT_W-1:0]  blk_cnt_q;
  logic [IDX_W-1:0]  byte_idx_q;
  logic [CNT_W:0]    beats_rcvd_q;
  logic [CNT_W:0]    beats_req;
  logic [BEAT_W-1:0] buf_q;
  logic              buf_valid_q;
  logic              run;
  logic              byte_last;
  logic              out_hs;
  logic              in_hs;

  assign run       = (state_q == RUN);
  assign byte_last = (byte_idx_q == IDX_W'(EPB - 1));
  assign beats_req = ({1'b0, nb_q} + (CNT_W+1)'(EPB - 1)) >> IDX_W;

  assign blk_exp_valid_o = run && buf_valid_q;
  assign blk_exp_o       = buf_q[byte_idx_q*EXP_W +: EXP_W];
  assign blk_idx_o       = blk_cnt_q;
  assign last_o          = blk_exp_valid_o &&
                           (blk_cnt_q == nb_q - CNT_W'(1));
  assign out_hs          = blk_exp_valid_o && blk_exp_ready_i;

  assign exp_ready_o = run &&
                       (!buf_valid_q || (out_hs && (byte_last || last_o))) &&
                       (beats_rcvd_q < beats_req);
  assign in_hs       = exp_valid_i && exp_ready_o;

  assign busy_o = (state_q != IDLE);
  assign done_o = (state_q == DONE);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) state_q <= IDLE;
    else                  state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (start_i) state_d = (num_blocks_i == '0) ? DONE : RUN;
      end
      (state_q == RUN): begin
        if (out_hs && last_o) state_d = DONE;
      end
      (state_q == DONE): state_d = IDLE;
      default:           state_d = IDLE;
    endcase
  end

  // Job counters and beat buffer; new beat wins over consuming the old one
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      nb_q         <= '0;
      blk_cnt_q    <= '0;
      byte_idx_q   <= '0;
      beats_rcvd_q <= '0;
      buf_q        <= '0;
      buf_valid_q  <= 1'b0;
    end else begin
      if ((state_q == IDLE) && start_i && (num_blocks_i != '0)) begin
        nb_q         <= num_blocks_i;
        blk_cnt_q    <= '0;
        byte_idx_q   <= '0;
        beats_rcvd_q <= '0;
        buf_valid_q  <= 1'b0;
      end
      if (out_hs) begin
        blk_cnt_q  <= blk_cnt_q + CNT_W'(1);
        byte_idx_q <= byte_last ? '0 : byte_idx_q + IDX_W'(1);
      end
      if (in_hs) begin
        buf_q        <= exp_data_i;
        buf_valid_q  <= 1'b1;
        beats_rcvd_q <= beats_rcvd_q + (CNT_W+1)'(1);
      end else if (out_hs && (byte_last || last_o)) begin
        buf_valid_q <= 1'b0;
      end
    end
  end

`ifdef REDMULE_MX_EXP_CHECK_EN
  logic err_q;
  logic err_set;

  assign err_set = (exp_valid_i && !run) ||
                   (exp_valid_i && run && (beats_rcvd_q >= beats_req)) ||
                   (start_i && busy_o);

  // Sticky protocol error; a new job clears it
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i)                  err_q <= 1'b0;
    else if (err_set)                      err_q <= 1'b1;
    else if ((state_q == IDLE) && start_i) err_q <= 1'b0;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: doc/redmule_mx_exp_unpacker.md
Name: redmule_mx_exp_unpacker

Overview:
- Sits directly downstream of the MX exponent stream sources (X and W exp); one instance per exponent stream.
- Consumes 64-byte exponent beats as the memory scheduler addresses them (linear; tot_len = ceil(ceil(M*K/32)/64)).
- Emits one 8-bit shared block exponent per handshake, in block order, to the MX decode path.
- Counts exactly num_blocks exponents per job, drops the padding bytes of the final partial beat, and pulses done when the job completes.

Parameters:
- BEAT_W, 512, exponent beat width in bits (DW); must be a multiple of EXP_W.
- EXP_W, 8, bits per shared exponent.
- CNT_W, 32, width of the block counters.
- localparam EPB = BEAT_W/EXP_W (64), exponents per beat.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- clear_i  in  1  synchronous soft clear, active-high; same effect as rst_i
- start_i  in  1  job start pulse; samples num_blocks_i
- num_blocks_i  in  CNT_W  exponents in the job, = ceil(rows*cols/32)
- exp_valid_i  in  1  beat valid
- exp_ready_o  out  1  beat ready
- exp_data_i  in  BEAT_W  beat; byte 0 = LSBs = lowest block index
- blk_exp_valid_o  out  1  exponent valid
- blk_exp_ready_i  in  1  exponent ready
- blk_exp_o  out  EXP_W  current exponent
- blk_idx_o  out  CNT_W  index of current exponent within the job
- last_o  out  1  current exponent is index num_blocks-1
- busy_o  out  1  FSM not IDLE
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  protocol error flag (see Optional Feature)

Behaviour:
- Reset and clear: state IDLE; beat buffer invalid; counters 0; all outputs 0. clear_i is equivalent to rst_i. rst_i or clear_i mid-job aborts the job with no done_o and discards the buffered beat.
- FSM states:
  - IDLE: exp_ready_o=0. On start_i with num_blocks_i==0, go to DONE. On start_i with num_blocks_i>0, latch num_blocks into nb_q, zero blk_cnt_q and byte_idx_q, go to RUN.
  - RUN: stays in RUN until the handshake on exponent nb_q-1, then goes to DONE.
  - DONE: done_o=1 for exactly one cycle, then IDLE.
- start_i is ignored outside IDLE.
- Beat buffer: one BEAT_W register plus a valid bit.
- Beat accept condition: exp_ready_o = RUN && (!buf_valid || (out_hs && (byte_idx_q==EPB-1 || last_o)) ) && beats_rcvd_q < ceil(nb_q/EPB).
  - exp_ready_o depends combinationally on blk_exp_ready_i. This gives full throughput: 1 exponent/cycle across beat boundaries with no bubble.
  - Beats beyond the required count are never accepted; exp_ready_o stays low.
- Output:
  - blk_exp_valid_o = RUN && buf_valid.
  - blk_exp_o = buf[byte_idx_q*EXP_W +: EXP_W].
  - blk_idx_o = blk_cnt_q.
  - last_o = blk_exp_valid_o && (blk_cnt_q == nb_q-1).
- On each output handshake (out_hs):
  - blk_cnt_q increments.
  - byte_idx_q increments, wrapping EPB-1 -> 0.
  - buf_valid clears unless a new beat is accepted in the same cycle; simultaneous consume-last-byte and accept loads the new beat with buf_valid held at 1.
- Partial final beat: after last_o handshakes, remaining bytes are discarded and buf_valid clears.
- Output stability: blk_exp_o, blk_idx_o and last_o hold while blk_exp_valid_o && !blk_exp_ready_i.
- Latency: first exponent is valid the cycle after the first beat handshake. done_o asserts the cycle after the last_o handshake.
- Arithmetic: the beat count ceil(nb/EPB) = (nb + EPB-1) >> log2(EPB) is computed in CNT_W+1 bits so that no overflow occurs at nb = 2^CNT_W-1.

Optional Feature:
- Macro: REDMULE_MX_EXP_CHECK_EN.
- Defined: err_o is a sticky flag, cleared only by rst_i, clear_i or start_i accepted in IDLE. It sets the next cycle on any of:
  - exp_valid_i in IDLE or DONE;
  - exp_valid_i in RUN while all required beats have been received;
  - start_i while busy_o.
  Data flow is unaffected.
- Not defined: err_o is tied to 0 and no checker logic exists.

Decomposition:
- redmule_pkg gains:
  - MX_BLK_SIZE=32;
  - MX_EXP_W=8;
  - typedef mx_exp_unpack_state_e {IDLE, RUN, DONE}.
- Single module; no sub-module. The byte-select mux is inline.

Test Plan:
- num_blocks=64, one beat with bytes 0x00..0x3F, ready always 1 -> 64 consecutive exponents 0x00..0x3F, blk_idx 0..63, last_o at idx 63, done_o exactly 1 cycle later.
- num_blocks=100, two beats presented back-to-back, ready=1 -> 100 exponents with no bubble at idx 63->64; bytes 36..63 of beat 2 never output; exactly 2 beats accepted; exp_ready_o=0 afterwards.
- Same as previous with blk_exp_ready_i random at 50% -> output sequence identical; blk_exp_o stable while stalled; beat 2 accepted only on the cycle idx 63 handshakes.
- start_i with num_blocks=0 -> done_o the cycle after IDLE->DONE, no beat accepted, blk_exp_valid_o never high.
- clear_i asserted after 10 exponents of a 64-block job -> next cycle IDLE, busy_o=0, no done_o; a new job with num_blocks=4 then outputs bytes 0..3 of its first beat.
- With REDMULE_MX_EXP_CHECK_EN: exp_valid_i=1 in IDLE -> err_o=1 the next cycle and held until start_i; without the macro err_o stays 0.
